// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver/consumer side signals of the UART receive FIFO
interface uart_rx_fifo_if #(parameter int LGFLEN = 4);
  logic i_wr;
  logic [7:0] i_data;
  logic i_parity_err;
  logic i_frame_err;
  logic i_break;
  logic i_rd;
  logic i_flush;
  logic i_clr_status;
  logic [7:0] o_rdata;
  logic o_rperr;
  logic o_rferr;
  logic o_empty_n;
  logic [LGFLEN:0] o_fill;
  logic o_half_full;
  logic o_overflow;
  logic o_break_seen;
  modport master (
    output i_wr, i_data, i_parity_err, i_frame_err, i_break, i_rd, i_flush, i_clr_status,
    input o_rdata, o_rperr, o_rferr, o_empty_n, o_fill, o_half_full, o_overflow, o_break_seen
  );
  modport slave (
    input i_wr, i_data, i_parity_err, i_frame_err, i_break, i_rd, i_flush, i_clr_status,
    output o_rdata, o_rperr, o_rferr, o_empty_n, o_fill, o_half_full, o_overflow, o_break_seen
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word fall-through receive FIFO with error tags and sticky overflow/break flags
module uart_rx_fifo #(parameter int LGFLEN = 4) (
  input logic i_clk,
  input logic i_reset_n,
  uart_rx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << LGFLEN;
  logic [9:0] mem [DEPTH];
  logic [LGFLEN-1:0] wptr, rptr, rptr_nx;
  logic [LGFLEN:0] fill;
  logic [9:0] wdata, head, head_q;
  logic full, pop, push, drop, brk_q, overflow, break_seen;
  always_comb begin
    wdata = {bus.i_frame_err, bus.i_parity_err, bus.i_data};
    full = fill == (LGFLEN+1)'(DEPTH);
    pop = bus.i_rd & (fill != '0) & ~bus.i_flush;
    push = bus.i_wr & ~bus.i_break & (~full | pop) & ~bus.i_flush;
    drop = bus.i_wr & ~bus.i_break & full & ~bus.i_rd;
    rptr_nx = rptr + LGFLEN'(pop);
    // a push into a FIFO that is (or becomes) empty bypasses storage so it shows up next cycle
    head = (fill == (LGFLEN+1)'(pop)) ? wdata : mem[rptr_nx];
  end
  always_ff @(posedge i_clk)
    if (push) mem[wptr] <= wdata;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      wptr <= '0;
      rptr <= '0;
      fill <= '0;
      head_q <= '0;
      brk_q <= 1'b0;
      overflow <= 1'b0;
      break_seen <= 1'b0;
    end else begin
      wptr <= bus.i_flush ? '0 : wptr + LGFLEN'(push);
      rptr <= bus.i_flush ? '0 : rptr_nx;
      fill <= bus.i_flush ? '0 : fill + (LGFLEN+1)'(push) - (LGFLEN+1)'(pop);
      head_q <= head;
      brk_q <= bus.i_break;
      overflow <= drop | (overflow & ~bus.i_clr_status);
      break_seen <= (bus.i_break & ~brk_q) | (break_seen & ~bus.i_clr_status);
    end
  assign bus.o_rdata = head_q[7:0];
  assign bus.o_rperr = head_q[8];
  assign bus.o_rferr = head_q[9];
  assign bus.o_fill = fill;
  assign bus.o_empty_n = fill != '0;
  assign bus.o_half_full = fill >= (LGFLEN+1)'(DEPTH / 2);
  assign bus.o_overflow = overflow;
  assign bus.o_break_seen = break_seen;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo with LGFLEN=4
module tb_uart_rx_fifo;
  logic clk, rst_n;
  int tests, fails;
  logic [7:0] q[$];
  logic [7:0] d;
  logic do_push, do_pop;
  uart_rx_fifo_if #(.LGFLEN(4)) bus();
  uart_rx_fifo #(.LGFLEN(4)) dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push1(input logic [7:0] v);
    bus.i_wr = 1'b1;
    bus.i_data = v;
    tick();
    bus.i_wr = 1'b0;
  endtask
  task automatic pop1();
    bus.i_rd = 1'b1;
    tick();
    bus.i_rd = 1'b0;
  endtask
  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.i_wr = 0; bus.i_data = 0; bus.i_parity_err = 0; bus.i_frame_err = 0;
    bus.i_break = 0; bus.i_rd = 0; bus.i_flush = 0; bus.i_clr_status = 0;
    repeat (2) tick();
    chk("rst_fill", 32'(bus.o_fill), 0);
    chk("rst_empty_n", 32'(bus.o_empty_n), 0);
    chk("rst_rdata", 32'(bus.o_rdata), 0);
    chk("rst_overflow", 32'(bus.o_overflow), 0);
    chk("rst_break", 32'(bus.o_break_seen), 0);
    rst_n = 1'b1;
    tick();
    // single push with parity error, then pop
    bus.i_parity_err = 1'b1;
    push1(8'h5A);
    bus.i_parity_err = 1'b0;
    chk("single_empty_n", 32'(bus.o_empty_n), 1);
    chk("single_rdata", 32'(bus.o_rdata), 32'h5A);
    chk("single_rperr", 32'(bus.o_rperr), 1);
    chk("single_rferr", 32'(bus.o_rferr), 0);
    chk("single_fill", 32'(bus.o_fill), 1);
    pop1();
    chk("pop_empty_n", 32'(bus.o_empty_n), 0);
    chk("pop_fill", 32'(bus.o_fill), 0);
    pop1();
    chk("rd_empty_fill", 32'(bus.o_fill), 0);
    chk("rd_empty_ovf", 32'(bus.o_overflow), 0);
    // fill to full, checking the half-full threshold on every step
    for (int i = 0; i < 16; i++) begin
      bus.i_frame_err = (i == 0);
      push1(8'(i));
      chk("fill_count", 32'(bus.o_fill), 32'(i + 1));
      chk("fill_half", 32'(bus.o_half_full), 32'(i + 1 >= 8));
    end
    bus.i_frame_err = 1'b0;
    chk("full_rferr_head", 32'(bus.o_rferr), 1);
    push1(8'hFF);
    chk("drop_overflow", 32'(bus.o_overflow), 1);
    chk("drop_fill", 32'(bus.o_fill), 16);
    bus.i_clr_status = 1'b1;
    tick();
    bus.i_clr_status = 1'b0;
    chk("clr_overflow", 32'(bus.o_overflow), 0);
    chk("full_head", 32'(bus.o_rdata), 0);
    // push and pop together at full
    bus.i_wr = 1'b1; bus.i_data = 8'hAA; bus.i_rd = 1'b1;
    tick();
    bus.i_wr = 1'b0; bus.i_rd = 1'b0;
    chk("simul_fill", 32'(bus.o_fill), 16);
    chk("simul_overflow", 32'(bus.o_overflow), 0);
    for (int i = 1; i < 17; i++) begin
      chk("drain_data", 32'(bus.o_rdata), (i == 16) ? 32'hAA : 32'(i));
      pop1();
    end
    chk("drain_empty_n", 32'(bus.o_empty_n), 0);
    // break blocks pushes and sets the sticky flag
    push1(8'h33);
    bus.i_break = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.i_wr = i[0];
      bus.i_data = 8'(i);
      tick();
    end
    bus.i_wr = 1'b0;
    chk("brk_fill", 32'(bus.o_fill), 1);
    chk("brk_seen", 32'(bus.o_break_seen), 1);
    chk("brk_no_ovf", 32'(bus.o_overflow), 0);
    bus.i_break = 1'b0; bus.i_clr_status = 1'b1;
    tick();
    chk("brk_clr", 32'(bus.o_break_seen), 0);
    bus.i_break = 1'b1;
    tick();
    chk("brk_set_wins", 32'(bus.o_break_seen), 1);
    tick();
    chk("brk_clr_level", 32'(bus.o_break_seen), 0);
    bus.i_break = 1'b0; bus.i_clr_status = 1'b0;
    chk("brk_head", 32'(bus.o_rdata), 32'h33);
    pop1();
    // interleaved traffic across pointer wrap, checked against a queue
    for (int c = 0; c < 40; c++) begin
      do_push = (q.size() < 2) || (c % 2 == 0 && q.size() < 3);
      do_pop = (q.size() >= 2) || (c % 3 == 0 && q.size() >= 1);
      d = 8'(c * 7 + 1);
      if (do_pop) begin
        chk("wrap_data", 32'(bus.o_rdata), 32'(q[0]));
        void'(q.pop_front());
      end
      if (do_push) q.push_back(d);
      bus.i_wr = do_push; bus.i_data = d; bus.i_rd = do_pop;
      tick();
      chk("wrap_fill", 32'(bus.o_fill), 32'(q.size()));
    end
    bus.i_wr = 1'b0; bus.i_rd = 1'b0;
    while (q.size() > 0) begin
      chk("wrap_tail", 32'(bus.o_rdata), 32'(q[0]));
      void'(q.pop_front());
      pop1();
    end
    chk("wrap_empty_n", 32'(bus.o_empty_n), 0);
    // flush discards a same-cycle push
    for (int i = 0; i < 5; i++) push1(8'(8'h60 + i));
    chk("pre_flush_fill", 32'(bus.o_fill), 5);
    bus.i_flush = 1'b1; bus.i_wr = 1'b1; bus.i_data = 8'hEE;
    tick();
    bus.i_flush = 1'b0; bus.i_wr = 1'b0;
    chk("flush_fill", 32'(bus.o_fill), 0);
    chk("flush_empty_n", 32'(bus.o_empty_n), 0);
    push1(8'h77);
    chk("post_flush_data", 32'(bus.o_rdata), 32'h77);
    chk("post_flush_fill", 32'(bus.o_fill), 1);
    // asynchronous reset in the middle of a push burst
    bus.i_break = 1'b1;
    tick();
    bus.i_break = 1'b0;
    push1(8'h11);
    bus.i_wr = 1'b1; bus.i_data = 8'h22;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_fill", 32'(bus.o_fill), 0);
    chk("arst_empty_n", 32'(bus.o_empty_n), 0);
    chk("arst_rdata", 32'(bus.o_rdata), 0);
    chk("arst_half", 32'(bus.o_half_full), 0);
    chk("arst_break", 32'(bus.o_break_seen), 0);
    bus.i_wr = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_fill", 32'(bus.o_fill), 0);
    push1(8'h44);
    chk("post_rst_data", 32'(bus.o_rdata), 32'h44);
    chk("post_rst_fill1", 32'(bus.o_fill), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter LGFLEN, default 4, log2 of FIFO depth (depth = 2^LGFLEN entries, legal 2..10).
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state is clocked on its rising edge.
REQ-003 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i_wr, input, 1, receive strobe from the UART receiver, one cycle per byte.
REQ-005 SHALL have port i_data, input, 8, received byte, qualified by i_wr.
REQ-006 SHALL have port i_parity_err, input, 1, parity error for the byte, qualified by i_wr.
REQ-007 SHALL have port i_frame_err, input, 1, framing error for the byte, qualified by i_wr.
REQ-008 SHALL have port i_break, input, 1, level break indication from the receiver.
REQ-009 SHALL have port i_rd, input, 1, pop strobe from the consumer.
REQ-010 SHALL have port i_flush, input, 1, synchronous FIFO clear.
REQ-011 SHALL have port i_clr_status, input, 1, synchronous clear of the sticky flags.
REQ-012 SHALL have port o_rdata, output, 8, head-entry byte (first-word fall-through).
REQ-013 SHALL have port o_rperr, output, 1, head-entry parity error flag.
REQ-014 SHALL have port o_rferr, output, 1, head-entry frame error flag.
REQ-015 SHALL have port o_empty_n, output, 1, high when at least one entry is stored.
REQ-016 SHALL have port o_fill, output, LGFLEN+1, number of stored entries.
REQ-017 SHALL have port o_half_full, output, 1, high when o_fill >= 2^(LGFLEN-1).
REQ-018 SHALL have port o_overflow, output, 1, sticky flag for a dropped byte.
REQ-019 SHALL have port o_break_seen, output, 1, sticky flag for a break event.

Function
REQ-020 SHALL store 10-bit entries {frame_err, parity_err, data[7:0]} in a 2^LGFLEN circular buffer with LGFLEN-bit read and write pointers that wrap modulo depth.
REQ-021 SHALL accept a push when i_wr=1, i_break=0, and the FIFO is not full (or is full with an accepted pop in the same cycle).
REQ-022 SHALL drop a push when i_wr=1 and the FIFO is full with no same-cycle pop; the drop SHALL set o_overflow on the next cycle and leave contents and o_fill unchanged.
REQ-023 SHALL ignore i_wr while i_break=1: no entry is stored and o_overflow is not set.
REQ-024 SHALL accept a pop when i_rd=1 and o_empty_n=1; i_rd on an empty FIFO SHALL be ignored without error.
REQ-025 SHALL, on a simultaneous accepted push and pop, perform both and leave o_fill unchanged; when the FIFO is empty, a same-cycle i_rd SHALL be ignored and the push SHALL proceed.
REQ-026 SHALL make a pushed entry visible on o_rdata/o_rperr/o_rferr, with o_empty_n=1, in the cycle after the i_wr cycle (one-cycle write-to-read latency).
REQ-027 SHALL present the next entry on o_rdata in the cycle after an accepted pop.
REQ-028 SHALL update o_fill, o_empty_n, and o_half_full registered, one cycle after the push or pop that changes them.
REQ-029 SHALL set o_break_seen on the cycle after a 0->1 transition of i_break; it SHALL remain set until i_clr_status.
REQ-030 SHALL, on i_flush, reset the pointers and o_fill to 0 and drive o_empty_n=0 on the next cycle; a push or pop in the same cycle as i_flush SHALL be discarded.
REQ-031 SHALL, on i_clr_status, clear o_overflow and o_break_seen; a set event in the same cycle SHALL win and leave the flag set.
REQ-032 SHALL keep o_rdata/o_rperr/o_rferr don't-care while o_empty_n=0.

Reset
REQ-033 SHALL, on i_reset_n=0, immediately clear pointers, o_fill, o_empty_n, o_half_full, o_overflow, o_break_seen, and the i_break edge register, and drive o_rdata/o_rperr/o_rferr to 0.
REQ-034 SHALL NOT reset storage contents.
REQ-035 SHALL discard a push or pop in progress when reset is asserted mid-operation; the first push after deassertion SHALL land in entry 0.

Verification
REQ-036 SHALL be verified by a single push: i_wr with 0x5A, perr=1 -> next cycle o_empty_n=1, o_rdata=0x5A, o_rperr=1, o_fill=1; i_rd -> next cycle o_empty_n=0, o_fill=0.
REQ-037 SHALL be verified by a fill with LGFLEN=4: push 16 bytes 0x00..0x0F -> o_fill=16, o_half_full=1; push 0xFF -> o_overflow=1 and o_fill=16; pop 16 -> reads 0x00..0x0F in order.
REQ-038 SHALL be verified by a full-FIFO simultaneous push and pop: push 0xAA with i_rd at fill 16 -> o_fill stays 16, o_overflow stays 0, 0xAA is read last.
REQ-039 SHALL be verified by a break: i_break=1 for 20 cycles with i_wr pulses -> o_fill unchanged, o_break_seen=1; i_clr_status -> o_break_seen=0.
REQ-040 SHALL be verified by wrap-around: 40 interleaved push/pop cycles at fill 1-3 -> data order preserved across pointer wrap.
REQ-041 SHALL be verified by flush and reset: i_flush at fill 5 -> o_fill=0 next cycle; i_reset_n low mid-stream -> all outputs 0 asynchronously.
